// File: rtl/serialtopar_pkg.sv
// Shared definitions for the serial-to-parallel deserializer.
//   state_t       : alignment FSM states (HUNT, ALIGN, LOCKED)
//   COMMA_DEFAULT : default 8-bit alignment/idle symbol
package serialtopar_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

endpackage

// File: rtl/serialtopar_comma_detector.sv
// Serial shift register plus comma comparator.
//   clk     : bit-rate clock
//   reset   : synchronous, active-high; clears the shift register
//   in      : serial data, MSB of each word first
//   sr_next : shift register contents including the bit being sampled now
//   match   : sr_next equals COMMA (combinational)
module comma_detector
  import serialtopar_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = WIDTH'(COMMA_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic [WIDTH-1:0] sr_next,
  output logic             match
);

  logic [WIDTH-1:0] sr;

  // The word completed by the current bit is visible before the edge, so
  // the FSM can act on a full word at the same edge that samples its last bit.
  assign sr_next = {sr[WIDTH-2:0], in};
  assign match   = (sr_next == COMMA);

  always_ff @(posedge clk) begin
    if (reset) sr <= '0;
    else       sr <= sr_next;
  end

endmodule

// File: rtl/serialtopar_sync.sv
// Parametrised serial-to-parallel deserializer with comma alignment,
// lock acquisition and loss-of-sync recovery.
//   clk       : bit-rate clock, all logic on its rising edge
//   reset     : synchronous, active-high
//   in        : serial data, MSB first
//   data_par  : last aligned word (registered, held between boundaries)
//   valid_par : one-cycle strobe, data_par holds a non-comma word
//   word_stb  : one-cycle strobe at each aligned boundary while locked
//   locked    : high while the FSM is in LOCKED
//   sync_err  : one-cycle pulse for each misaligned comma while locked
// Handshake: valid_par/word_stb are push-only strobes with no ready; the
// downstream logic must capture data_par in the cycle the strobe is high.
module serialtopar_sync
  import serialtopar_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(COMMA_DEFAULT),
  parameter int               LOCK_COUNT = 4,
  parameter int               LOSS_COUNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic [WIDTH-1:0] data_par,
  output logic             valid_par,
  output logic             word_stb,
  output logic             locked,
  output logic             sync_err
);

  localparam int CW  = $clog2(WIDTH);
  localparam int CCW = $clog2(LOCK_COUNT + 1);
  localparam int ECW = $clog2(LOSS_COUNT + 1);

  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CCW-1:0] LOCK_TGT = CCW'(LOCK_COUNT);
  localparam logic [ECW-1:0] LOSS_TGT = ECW'(LOSS_COUNT);

  logic [WIDTH-1:0] sr_next;
  logic             match;

  comma_detector #(
    .WIDTH (WIDTH),
    .COMMA (COMMA)
  ) u_det (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .sr_next (sr_next),
    .match   (match)
  );

  // State is kept as a named signal so checkers can bind to it directly.
  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [CCW-1:0]   comma_cnt, comma_cnt_d;
  logic [ECW-1:0]   err_cnt, err_cnt_d;
  logic [WIDTH-1:0] data_d;
  logic             valid_d, stb_d, serr_d;

  logic             boundary;
  logic [CW-1:0]    cnt_inc;
  logic [CCW-1:0]   comma_inc;
  logic [ECW-1:0]   err_inc;

  assign boundary  = (cnt == LAST_BIT);
  assign cnt_inc   = boundary ? '0 : cnt + 1'b1;
  assign comma_inc = comma_cnt + 1'b1;
  assign err_inc   = err_cnt + 1'b1;
  assign locked    = (state == LOCKED);

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    comma_cnt_d = comma_cnt;
    err_cnt_d   = err_cnt;
    data_d      = data_par;
    valid_d     = 1'b0;
    stb_d       = 1'b0;
    serr_d      = 1'b0;
    case (state)
      HUNT: begin
        // Any bit position may start a word; the matching comma fixes the phase.
        if (match) begin
          cnt_d       = '0;
          comma_cnt_d = CCW'(1);
          err_cnt_d   = '0;
          state_d     = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
        end
      end
      ALIGN: begin
        cnt_d = cnt_inc;
        if (boundary) begin
          if (match) begin
            comma_cnt_d = comma_inc;
            if (comma_inc == LOCK_TGT) begin
              state_d   = LOCKED;
              err_cnt_d = '0;
            end
          end else begin
            state_d     = HUNT;
            comma_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        cnt_d = cnt_inc;
        if (boundary) begin
          data_d  = sr_next;
          stb_d   = 1'b1;
          valid_d = !match;
          if (match) err_cnt_d = '0;
        end else if (match) begin
          // A comma at the wrong phase means the lane has slipped.
          serr_d    = 1'b1;
          err_cnt_d = err_inc;
          if (err_inc == LOSS_TGT) begin
            state_d     = HUNT;
            err_cnt_d   = '0;
            comma_cnt_d = '0;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      cnt       <= '0;
      comma_cnt <= '0;
      err_cnt   <= '0;
      data_par  <= '0;
      valid_par <= 1'b0;
      word_stb  <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      comma_cnt <= comma_cnt_d;
      err_cnt   <= err_cnt_d;
      data_par  <= data_d;
      valid_par <= valid_d;
      word_stb  <= stb_d;
      sync_err  <= serr_d;
    end
  end

endmodule

// File: tb/tb_serialtopar_sync.sv
// Bench for serialtopar_sync: an 8-bit default instance and a 10-bit,
// LOCK_COUNT=1 instance, both checked every cycle against a word-phase model.
module tb_serialtopar_sync;

  localparam int M_HUNT  = 0;
  localparam int M_ALIGN = 1;
  localparam int M_LOCK  = 2;

  typedef struct {
    int mode;
    int window;
    int anchor;
    int commas;
    int errs;
    int data;
    bit valid;
    bit stb;
    bit serr;
  } model_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic in8   = 1'b0;
  logic in10  = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] data8;
  logic       valid8, stb8, locked8, serr8;
  logic [9:0] data10;
  logic       valid10, stb10, locked10, serr10;

  serialtopar_sync dut8 (
    .clk       (clk),
    .reset     (reset),
    .in        (in8),
    .data_par  (data8),
    .valid_par (valid8),
    .word_stb  (stb8),
    .locked    (locked8),
    .sync_err  (serr8)
  );

  serialtopar_sync #(
    .WIDTH      (10),
    .COMMA      (10'h17C),
    .LOCK_COUNT (1),
    .LOSS_COUNT (3)
  ) dut10 (
    .clk       (clk),
    .reset     (reset),
    .in        (in10),
    .data_par  (data10),
    .valid_par (valid10),
    .word_stb  (stb10),
    .locked    (locked10),
    .sync_err  (serr10)
  );

  int checks = 0;
  int errors = 0;
  int t      = 0;
  bit cmp_en = 0;
  bit done8  = 0;
  bit done10 = 0;
  model_t m8, m10;

  // ---------------- reference model ----------------
  // Words are framed by absolute time: a boundary is any edge a whole
  // number of words after the edge that completed the anchoring comma.
  function automatic model_t step(model_t m, int w, int comma, int lockc,
                                  int lossc, bit rst, bit b, int now);
    model_t n;
    bit hit, on_b;
    n = m;
    n.valid = 0;
    n.stb   = 0;
    n.serr  = 0;
    if (rst) begin
      n.mode = M_HUNT; n.window = 0; n.commas = 0; n.errs = 0; n.data = 0;
      return n;
    end
    n.window = ((m.window << 1) | int'(b)) & ((1 << w) - 1);
    hit  = (n.window == comma);
    on_b = (((now - m.anchor) % w) == 0);
    if (m.mode == M_HUNT) begin
      if (hit) begin
        n.anchor = now;
        n.commas = 1;
        n.errs   = 0;
        n.mode   = (lockc == 1) ? M_LOCK : M_ALIGN;
      end
    end else if (m.mode == M_ALIGN) begin
      if (on_b) begin
        if (hit) begin
          n.commas = m.commas + 1;
          if (n.commas == lockc) begin n.mode = M_LOCK; n.errs = 0; end
        end else begin
          n.mode = M_HUNT; n.commas = 0;
        end
      end
    end else begin
      if (on_b) begin
        n.data  = n.window;
        n.stb   = 1;
        n.valid = !hit;
        if (hit) n.errs = 0;
      end else if (hit) begin
        n.serr = 1;
        n.errs = m.errs + 1;
        if (n.errs == lossc) begin n.mode = M_HUNT; n.errs = 0; n.commas = 0; end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m8  = step(m8, 8, 'hBC, 4, 3, reset, in8, t);
    m10 = step(m10, 10, 'h17C, 1, 3, reset, in10, t);
    t++;
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("m8.data",    int'(data8),    m8.data);
      cmp("m8.valid",   int'(valid8),   int'(m8.valid));
      cmp("m8.stb",     int'(stb8),     int'(m8.stb));
      cmp("m8.locked",  int'(locked8),  int'(m8.mode == M_LOCK));
      cmp("m8.serr",    int'(serr8),    int'(m8.serr));
      cmp("m10.data",   int'(data10),   m10.data);
      cmp("m10.valid",  int'(valid10),  int'(m10.valid));
      cmp("m10.stb",    int'(stb10),    int'(m10.stb));
      cmp("m10.locked", int'(locked10), int'(m10.mode == M_LOCK));
      cmp("m10.serr",   int'(serr10),   int'(m10.serr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic drv8(input bit b);
    @(negedge clk);
    in8 = b;
  endtask

  task automatic word8(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) drv8(w[i]);
  endtask

  task automatic drv10(input bit b);
    @(negedge clk);
    in10 = b;
  endtask

  task automatic word10(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) drv10(w[i]);
  endtask

  // ---------------- 8-bit stimulus ----------------
  initial begin
    logic [7:0] w;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1;
    cmp("rst.data",   int'(data8),  0);
    cmp("rst.valid",  int'(valid8), 0);
    cmp("rst.stb",    int'(stb8),   0);
    cmp("rst.locked", int'(locked8), 0);
    cmp("rst.serr",   int'(serr8),  0);
    @(negedge clk);
    reset = 0;

    // Lock acquisition at a 3-bit offset.
    repeat (3) drv8(1'($urandom_range(0, 1)));
    for (int k = 0; k < 4; k++) begin
      word8(8'hBC);
      settle();
      cmp("acq.locked", int'(locked8), (k == 3) ? 1 : 0);
    end
    word8(8'h5A);
    settle();
    cmp("acq.valid_5a", int'(valid8), 1);
    cmp("acq.data_5a",  int'(data8),  'h5A);
    word8(8'hC3);
    settle();
    cmp("acq.valid_c3", int'(valid8), 1);
    cmp("acq.data_c3",  int'(data8),  'hC3);

    // Idle commas while locked.
    repeat (3) begin
      word8(8'hBC);
      settle();
      cmp("idle.stb",   int'(stb8),   1);
      cmp("idle.valid", int'(valid8), 0);
      cmp("idle.data",  int'(data8),  'hBC);
    end

    // One-bit slip: three misaligned commas, then relock at the new phase.
    drv8(1'b0);
    for (int k = 0; k < 3; k++) begin
      word8(8'hBC);
      settle();
      cmp("slip.serr",   int'(serr8),   1);
      cmp("slip.locked", int'(locked8), (k < 2) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      word8(8'hBC);
      settle();
      cmp("relock.locked", int'(locked8), (k == 3) ? 1 : 0);
    end
    word8(8'h77);
    settle();
    cmp("relock.valid", int'(valid8), 1);
    cmp("relock.data",  int'(data8),  'h77);

    // Reset at bit 5 of a data word while locked.
    w = 8'hA5;
    for (int i = 7; i >= 3; i--) drv8(w[i]);
    @(negedge clk);
    reset = 1;
    in8   = w[2];
    settle();
    cmp("mrst.data",   int'(data8),   0);
    cmp("mrst.valid",  int'(valid8),  0);
    cmp("mrst.stb",    int'(stb8),    0);
    cmp("mrst.locked", int'(locked8), 0);
    cmp("mrst.serr",   int'(serr8),   0);
    @(negedge clk);
    reset = 0;
    in8   = w[1];
    drv8(w[0]);
    settle();
    cmp("mrst.stale_valid", int'(valid8), 0);

    // Interrupted alignment.
    word8(8'hBC);
    word8(8'hBC);
    word8(8'h00);
    settle();
    cmp("intr.locked_00", int'(locked8), 0);
    for (int k = 0; k < 4; k++) begin
      word8(8'hBC);
      settle();
      cmp("intr.locked", int'(locked8), (k == 3) ? 1 : 0);
    end
    word8(8'h11);
    settle();
    cmp("intr.valid", int'(valid8), 1);
    cmp("intr.data",  int'(data8),  'h11);

    // Random words, commas and slips.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: word8(8'hBC);
        1: begin drv8(1'($urandom_range(0, 1))); word8(8'($urandom)); end
        default: word8(8'($urandom));
      endcase
    end
    done8 = 1;

    for (int i = 0; i < 200 && !done10; i++) @(posedge clk);
    if (!done10) cmp("done10_timeout", 0, 1);
    repeat (3) settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- 10-bit stimulus ----------------
  initial begin
    wait (reset == 1'b0);
    word10(10'h17C);
    settle();
    cmp("p10.locked", int'(locked10), 1);
    cmp("p10.stb0",   int'(stb10),    0);
    word10(10'h2A5);
    settle();
    cmp("p10.stb1",   int'(stb10),   1);
    cmp("p10.valid1", int'(valid10), 1);
    cmp("p10.data1",  int'(data10),  'h2A5);
    word10(10'h0F0);
    settle();
    cmp("p10.valid2", int'(valid10), 1);
    cmp("p10.data2",  int'(data10),  'h0F0);
    word10(10'h17C);
    settle();
    cmp("p10.stb3",   int'(stb10),   1);
    cmp("p10.valid3", int'(valid10), 0);
    cmp("p10.data3",  int'(data10),  'h17C);
    while (!done8) begin
      case ($urandom_range(0, 2))
        0: word10(10'h17C);
        1: begin drv10(1'($urandom_range(0, 1))); word10(10'($urandom)); end
        default: word10(10'($urandom));
      endcase
    end
    done10 = 1;
  end

endmodule

// File: doc/serialtopar_sync.md
# serialtopar_sync

Parametrised serial-to-parallel deserializer with comma-based word alignment, lock acquisition and loss-of-sync recovery. It sits at the receive end of the PHY, after the serial lane, and delivers aligned WIDTH-bit words with a valid strobe to the downstream byte/word logic. It generalises the fixed 8-bit, sticky-lock deserializer in three ways: parametrised width and comma, a single bit-rate clock with a word strobe, and automatic re-hunt when alignment is lost.

## Interface
- WIDTH, 8: word width in bits, ≥ 4.
- COMMA, 8'hBC: WIDTH-bit alignment/idle symbol.
- LOCK_COUNT, 4: consecutive aligned commas required to lock, ≥ 1.
- LOSS_COUNT, 3: misaligned commas that drop lock, ≥ 1.
- clk  input  1  bit-rate clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  1  serial data, MSB of each word first.
- data_par  output  WIDTH  last aligned word, registered.
- valid_par  output  1  one-cycle strobe: data_par holds a non-comma word.
- word_stb  output  1  one-cycle strobe at every aligned word boundary while locked, including commas.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on each misaligned comma while locked.

## Operation
- Shift register: sr_next = {sr[WIDTH-2:0], in}; sr <= sr_next every cycle outside reset.
- Bit counter cnt, $clog2(WIDTH) bits, modulo WIDTH. A boundary occurs when cnt == WIDTH-1, where sr_next is a complete word.
- States, held in the shared package: HUNT, ALIGN, LOCKED.
- HUNT: compare sr_next to COMMA every cycle. On a match: cnt <= 0, comma_cnt <= 1, then ALIGN, or LOCKED directly if LOCK_COUNT == 1. cnt is don't-care while hunting.
- ALIGN: cnt increments. At a boundary:
  - sr_next == COMMA: comma_cnt++. On reaching LOCK_COUNT, go to LOCKED and clear err_cnt.
  - otherwise: go to HUNT and clear comma_cnt.
  - Off-boundary comma matches are ignored.
- LOCKED: cnt increments. At every boundary: data_par <= sr_next; word_stb <= 1; valid_par <= (sr_next != COMMA).
  - Aligned comma: err_cnt <= 0.
  - Off-boundary comma match: sync_err <= 1 and err_cnt++. When err_cnt reaches LOSS_COUNT, go to HUNT; clear err_cnt and comma_cnt; locked drops on the same edge.
  - Non-comma data never affects err_cnt.
- data_par holds its value between boundaries and outside LOCKED. valid_par and word_stb are 0 outside LOCKED.
- Reset, on any edge with reset high, mid-word or mid-lock: state HUNT; sr, cnt, comma_cnt and err_cnt cleared; data_par = 0; valid_par, word_stb, locked and sync_err all 0.

## Timing
- Latency: the last bit of a word is sampled at edge k. data_par, valid_par and word_stb update at edge k and are visible during cycle k+1.
- Strobes are single-cycle pulses, asserted at most once per WIDTH cycles.
- Lock time from the first aligned comma's last bit: (LOCK_COUNT-1)·WIDTH cycles. locked rises at the edge sampling the last bit of the LOCK_COUNT-th comma.
- Stream after lock: the first word_stb comes one word later, at the next boundary.
- Lock loss: locked falls at the edge detecting the LOSS_COUNT-th misaligned comma.
- HUNT can re-acquire a comma on the cycle immediately after leaving LOCKED or ALIGN.

## Structure
- Package serialtopar_pkg: state enum (HUNT, ALIGN, LOCKED) and the default COMMA constant 8'hBC.
- Sub-module comma_detector (parameters WIDTH, COMMA): owns sr, produces sr_next and a combinational match flag.
- Top-level serialtopar_sync owns cnt, comma_cnt, err_cnt, the FSM and the output registers.

## Test plan
- Lock acquisition: with reset released, send 4×8'hBC followed by 8'h5A and 8'hC3, starting at an arbitrary bit offset of 3. Required: locked rises at the last bit of the 4th BC; valid_par pulses with data_par = 8'h5A, then 8'hC3, WIDTH cycles apart.
- Interrupted alignment: send BC, BC, 8'h00, BC×4, 8'h11. Required: the 8'h00 returns the FSM to HUNT; lock occurs only after the second BC run; the first valid word is 8'h11.
- Idle while locked: send BC words. Required: word_stb pulses every 8 cycles, valid_par stays 0, data_par = 8'hBC.
- Loss of sync: after lock, insert a 1-bit slip so that BC appears off-boundary 3 times. Required: sync_err pulses 3 times, locked drops on the 3rd; the FSM then relocks after 4 aligned BCs at the new offset.
- Reset mid-word: assert reset for 1 cycle at bit 5 of a data word while locked. Required: all outputs 0 the next cycle and state HUNT; no stale valid_par.
- Parametrisation: WIDTH = 10, COMMA = 10'h17C, LOCK_COUNT = 1. Required: lock on the first comma; 10-bit words are strobed every 10 cycles.
